// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
//   Shared definitions for the 7-segment scan reader:
//     - seg_bit_e      : bit position of each segment on the 7-bit bus
//     - SEG_PATTERNS   : canonical active-high pattern for nibbles 0..F
//     - SEG_ALT_7/9    : alternate glyphs accepted for 7 and 9
//     - state_e        : frame-assembly FSM states
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    typedef enum int unsigned {
        SEG_TOP = 0,
        SEG_UR  = 1,
        SEG_LR  = 2,
        SEG_BOT = 3,
        SEG_LL  = 4,
        SEG_UL  = 5,
        SEG_MID = 6
    } seg_bit_e;

    // Index i holds the glyph for nibble value i.
    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // 7 with the upper-left serif lit, 9 without the bottom bar.
    localparam logic [6:0] SEG_ALT_7 = SEG_PATTERNS[7] | (7'b1 << SEG_UL);
    localparam logic [6:0] SEG_ALT_9 = SEG_PATTERNS[9] & ~(7'b1 << SEG_BOT);

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        COLLECT = 2'd1,
        PUBLISH = 2'd2
    } state_e;

endpackage

// File: rtl/seven_seg_pattern_decode.sv
// -----------------------------------------------------------------------------
// seven_seg_pattern_decode
//   Combinational reverse map of an active-high 7-segment glyph to a nibble.
//   Ports:
//     pattern_i    [6:0]  active-high segment pattern
//     nibble_o     [3:0]  decoded value (0 when the pattern is not recognised)
//     pattern_ok_o        1 when pattern_i is a canonical or alternate glyph
// -----------------------------------------------------------------------------
module seven_seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] nibble_o,
    output logic       pattern_ok_o
);

    // NOTE: every output gets a default before the search loop so that no
    // path through the block leaves it unassigned, which would infer a latch.
    always_comb begin
        nibble_o     = 4'h0;
        pattern_ok_o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern_i == SEG_PATTERNS[i]) begin
                nibble_o     = 4'(i);
                pattern_ok_o = 1'b1;
            end
        end
        if (pattern_i == SEG_ALT_7) begin
            nibble_o     = 4'h7;
            pattern_ok_o = 1'b1;
        end
        if (pattern_i == SEG_ALT_9) begin
            nibble_o     = 4'h9;
            pattern_ok_o = 1'b1;
        end
    end

endmodule

// File: rtl/seven_seg_scan_reader.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_reader
//   Reads a time-multiplexed 7-segment bus, filters each dwell for stability,
//   decodes each digit and publishes a complete multi-digit word.
//   Parameters:
//     DIGITS          number of multiplexed digits (1..8)
//     STABLE          cycles a (seg, dig_sel) pair must hold before commit (>=2)
//     SEG_ACTIVE_LOW  1 = segment lines are active-low
//   Ports:
//     clk      the only clock
//     rst      synchronous, active-high reset
//     seg      [6:0]          segment lines
//     dig_sel  [DIGITS-1:0]   one-hot digit select, all-zero = blanking
//     value    [4*DIGITS-1:0] last complete word, nibble i from digit i
//     valid    one-cycle pulse when value is updated
//     err      one-cycle pulse on an invalid committed pattern / multi-hot select
//     busy     high while a frame is being collected
// -----------------------------------------------------------------------------
module seven_seg_scan_reader
    import seven_seg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int STABLE         = 3,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   value,
    output logic                  valid,
    output logic                  err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(STABLE + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // ---------------- input stage and stability filter ----------------
    logic [6:0]        seg_in;
    logic [6:0]        seg_q, seg_prev_q;
    logic [DIGITS-1:0] sel_q, sel_prev_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pair_same;
    logic              commit;

    assign seg_in    = SEG_ACTIVE_LOW ? ~seg : seg;
    assign pair_same = (seg_q == seg_prev_q) && (sel_q == sel_prev_q);

    always_comb begin
        cnt_d = cnt_q;
        if (!pair_same) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_W'(STABLE)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Fires only on the step into STABLE, so a long dwell commits once.
    assign commit = pair_same && (cnt_q == CNT_W'(STABLE - 1));

    // ---------------- commit classification ----------------
    logic [3:0]       nibble;
    logic             pattern_ok;
    logic [IDX_W-1:0] dig_idx;
    logic             sel_zero, sel_onehot;
    logic             good_commit, bad_commit;

    seven_seg_pattern_decode u_decode (
        .pattern_i    (seg_q),
        .nibble_o     (nibble),
        .pattern_ok_o (pattern_ok)
    );

    always_comb begin
        dig_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_q[i]) begin
                dig_idx = IDX_W'(i);
            end
        end
    end

    assign sel_zero    = (sel_q == '0);
    assign sel_onehot  = $onehot(sel_q);
    assign good_commit = commit && sel_onehot && pattern_ok;
    // Blanking (all-zero select) is never an error, whatever the segments show.
    assign bad_commit  = commit && !sel_zero && !(sel_onehot && pattern_ok);

    // ---------------- frame assembly FSM ----------------
    state_e              state_q, state_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    always_comb begin
        state_d  = state_q;
        seen_d   = seen_q;
        shadow_d = shadow_q;
        value_d  = value_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            SYNC: begin
                if (bad_commit) begin
                    err_d = 1'b1;
                end else if (good_commit && dig_idx == '0) begin
                    shadow_d[3:0] = nibble;
                    seen_d        = DIGITS'(1);
                    state_d       = (&seen_d) ? PUBLISH : COLLECT;
                end
            end
            COLLECT: begin
                if (bad_commit) begin
                    err_d   = 1'b1;
                    seen_d  = '0;
                    state_d = SYNC;
                end else if (good_commit) begin
                    shadow_d[4*int'(dig_idx) +: 4] = nibble;
                    seen_d[dig_idx]                = 1'b1;
                    if (&seen_d) begin
                        state_d = PUBLISH;
                    end
                end
            end
            PUBLISH: begin
                value_d = shadow_q;
                valid_d = 1'b1;
                seen_d  = '0;
                state_d = SYNC;
            end
            default: begin
                seen_d  = '0;
                state_d = SYNC;
            end
        endcase
    end

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q      <= '0;
            sel_q      <= '0;
            seg_prev_q <= '0;
            sel_prev_q <= '0;
            cnt_q      <= '0;
            state_q    <= SYNC;
            seen_q     <= '0;
            // NOTE: the shadow word is a handful of flops, not a RAM, so it is
            // cleared too; a reset mid-frame must leave no stale digits behind.
            shadow_q   <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            seg_q      <= seg_in;
            sel_q      <= dig_sel;
            seg_prev_q <= seg_q;
            sel_prev_q <= sel_q;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            seen_q     <= seen_d;
            shadow_q   <= shadow_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign value = value_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign busy  = (state_q == COLLECT);

endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_reader
//   Directed bench for the 7-segment scan reader. Two instances share the
//   same stimulus: one reads active-high segments, the other reads the
//   inverted lines with SEG_ACTIVE_LOW=1; both must behave identically.
//   Expected words are queued when a frame is driven and popped on valid.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_reader;

    localparam int DIGITS = 4;
    localparam int STABLE = 3;
    localparam int DWELL  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [6:0]  seg_n;
    logic [3:0]  dig_sel;

    logic [15:0] value_h, value_l;
    logic        valid_h, valid_l;
    logic        err_h, err_l;
    logic        busy_h, busy_l;

    assign seg_n = ~seg;

    always #5 clk = ~clk;

    seven_seg_scan_reader #(
        .DIGITS(DIGITS), .STABLE(STABLE), .SEG_ACTIVE_LOW(1'b0)
    ) u_dut_h (
        .clk(clk), .rst(rst), .seg(seg), .dig_sel(dig_sel),
        .value(value_h), .valid(valid_h), .err(err_h), .busy(busy_h)
    );

    seven_seg_scan_reader #(
        .DIGITS(DIGITS), .STABLE(STABLE), .SEG_ACTIVE_LOW(1'b1)
    ) u_dut_l (
        .clk(clk), .rst(rst), .seg(seg_n), .dig_sel(dig_sel),
        .value(value_l), .valid(valid_l), .err(err_l), .busy(busy_l)
    );

    int checks = 0;
    int errors = 0;
    int valid_cnt_h = 0, valid_cnt_l = 0;
    int err_cnt_h = 0, err_cnt_l = 0;
    logic [15:0] exp_q_h [$];
    logic [15:0] exp_q_l [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag, input logic [31:0] obs_h,
                              input logic [31:0] obs_l, input logic [31:0] exp);
        check({tag, " (active-high)"}, obs_h, exp);
        check({tag, " (active-low)"}, obs_l, exp);
    endtask

    // Scoreboard side: compare the published word whenever valid pulses.
    always @(negedge clk) begin
        if (valid_h === 1'b1) begin
            valid_cnt_h++;
            check("h valid with queued word", 32'(exp_q_h.size() != 0), 32'd1);
            if (exp_q_h.size() != 0) check("h value", value_h, exp_q_h.pop_front());
            check("h err alongside valid", err_h, 32'd0);
        end
        if (err_h === 1'b1) err_cnt_h++;
    end

    always @(negedge clk) begin
        if (valid_l === 1'b1) begin
            valid_cnt_l++;
            check("l valid with queued word", 32'(exp_q_l.size() != 0), 32'd1);
            if (exp_q_l.size() != 0) check("l value", value_l, exp_q_l.pop_front());
            check("l err alongside valid", err_l, 32'd0);
        end
        if (err_l === 1'b1) err_cnt_l++;
    end

    // Called on a falling edge; the pair is sampled by the next n rising edges.
    task automatic show(input logic [6:0] s, input logic [3:0] d, input int n);
        seg     = s;
        dig_sel = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        show(7'h00, 4'b0000, n);
    endtask

    task automatic expect_word(input logic [15:0] w);
        exp_q_h.push_back(w);
        exp_q_l.push_back(w);
    endtask

    task automatic frame(input logic [6:0] p0, input logic [6:0] p1,
                         input logic [6:0] p2, input logic [6:0] p3);
        show(p0, 4'b0001, DWELL);
        show(p1, 4'b0010, DWELL);
        show(p2, 4'b0100, DWELL);
        show(p3, 4'b1000, DWELL);
    endtask

    initial begin
        rst     = 1'b1;
        seg     = 7'h00;
        dig_sel = 4'b0000;
        repeat (3) @(negedge clk);

        // Reset state.
        check_both("reset value", value_h, value_l, 32'h0);
        check_both("reset valid", valid_h, valid_l, 32'h0);
        check_both("reset err", err_h, err_l, 32'h0);
        check_both("reset busy", busy_h, busy_l, 32'h0);
        rst = 1'b0;

        // Clean frame 0x0123.
        expect_word(16'h0123);
        show(7'h4F, 4'b0001, DWELL);
        show(7'h5B, 4'b0010, DWELL);
        show(7'h06, 4'b0100, DWELL);
        check_both("busy mid frame", busy_h, busy_l, 32'h1);
        show(7'h3F, 4'b1000, DWELL);
        idle(4);
        check_both("frame1 valid count", valid_cnt_h, valid_cnt_l, 32'd1);
        check_both("frame1 err count", err_cnt_h, err_cnt_l, 32'd0);
        check_both("frame1 value held", value_h, value_l, 32'h0123);

        // Short dwell on digit 2 must not commit; the full dwell afterwards does.
        expect_word(16'h0123);
        show(7'h4F, 4'b0001, DWELL);
        show(7'h5B, 4'b0010, DWELL);
        show(7'h06, 4'b0100, STABLE - 1);
        idle(1);
        check_both("busy after short dwell", busy_h, busy_l, 32'h1);
        show(7'h06, 4'b0100, DWELL);
        show(7'h3F, 4'b1000, DWELL);
        idle(4);
        check_both("short dwell valid count", valid_cnt_h, valid_cnt_l, 32'd2);
        check_both("short dwell err count", err_cnt_h, err_cnt_l, 32'd0);

        // Invalid glyph on digit 1 aborts the frame.
        show(7'h4F, 4'b0001, DWELL);
        show(7'h49, 4'b0010, DWELL);
        check_both("err at invalid commit", err_h, err_l, 32'h1);
        check_both("busy dropped after err", busy_h, busy_l, 32'h0);
        show(7'h06, 4'b0100, DWELL);
        show(7'h3F, 4'b1000, DWELL);
        idle(4);
        check_both("aborted frame valid count", valid_cnt_h, valid_cnt_l, 32'd2);
        check_both("aborted frame err count", err_cnt_h, err_cnt_l, 32'd1);
        expect_word(16'hCDEF);
        frame(7'h71, 7'h79, 7'h5E, 7'h39);
        idle(4);
        check_both("recovery valid count", valid_cnt_h, valid_cnt_l, 32'd3);
        check_both("recovery value", value_h, value_l, 32'hCDEF);

        // Multi-hot select is an error; long blanking is silent.
        show(7'h3F, 4'b0011, DWELL);
        check_both("err on multi-hot", err_h, err_l, 32'h1);
        idle(10);
        check_both("multi-hot/blank err count", err_cnt_h, err_cnt_l, 32'd2);
        check_both("blank valid count", valid_cnt_h, valid_cnt_l, 32'd3);

        // Alternate glyphs for 7 and 9.
        expect_word(16'hBA97);
        frame(7'h27, 7'h67, 7'h77, 7'h7C);
        idle(4);
        check_both("alternates valid count", valid_cnt_h, valid_cnt_l, 32'd4);
        check_both("alternates value", value_h, value_l, 32'hBA97);

        // Reset mid-frame, then a frame that starts at digit 2 is ignored.
        show(7'h4F, 4'b0001, DWELL);
        show(7'h5B, 4'b0010, DWELL);
        check_both("busy before reset", busy_h, busy_l, 32'h1);
        rst = 1'b1;
        idle(2);
        check_both("busy after reset", busy_h, busy_l, 32'h0);
        check_both("value after reset", value_h, value_l, 32'h0);
        rst = 1'b0;
        show(7'h06, 4'b0100, DWELL);
        show(7'h3F, 4'b1000, DWELL);
        idle(4);
        check_both("busy without digit 0", busy_h, busy_l, 32'h0);
        check_both("partial frame valid count", valid_cnt_h, valid_cnt_l, 32'd4);
        expect_word(16'h4567);
        frame(7'h07, 7'h7D, 7'h6D, 7'h66);
        idle(4);
        check_both("post-reset valid count", valid_cnt_h, valid_cnt_l, 32'd5);
        check_both("post-reset value", value_h, value_l, 32'h4567);
        check_both("final err count", err_cnt_h, err_cnt_l, 32'd2);
        check_both("scoreboard drained", exp_q_h.size(), exp_q_l.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
